// File: rtl/fb_scanout_if.sv
// fb_scanout_if: SRAM arbiter port (req/we/addr/rdata/ack/ready) and RGB888 pixel stream.
// The master side is the scanout engine; the slave side is the arbiter plus display timing block.
interface fb_scanout_if;
    logic        mem_req;
    logic        mem_we;
    logic [23:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        mem_ready;
    logic        pix_valid;
    logic        pix_ready;
    logic [23:0] pix_data;
    logic        pix_sof;
    logic        pix_eol;

    modport master (
        output mem_req, mem_we, mem_addr,
        input  mem_rdata, mem_ack, mem_ready,
        output pix_valid, pix_data, pix_sof, pix_eol,
        input  pix_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr,
        output mem_rdata, mem_ack, mem_ready,
        input  pix_valid, pix_data, pix_sof, pix_eol,
        output pix_ready
    );
endinterface

// File: rtl/fb_scanout.sv
// fb_scanout: raster-order R5G6B5 framebuffer reader feeding an RGB888 pixel stream.
// Optional macro SCANOUT_UNDERFLOW_CNT_EN builds the saturating consumer-starvation counter;
// without it underflow_cnt is tied to zero.
module fb_scanout #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_start,
    input  logic [19:0]        fb_base_addr,
    fb_scanout_if.master       bus,
    output logic               busy,
    output logic [15:0]        underflow_cnt
);
    localparam int unsigned XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int unsigned YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_DRAIN} state_e;

    typedef struct packed {
        logic [15:0] pix;
        logic        sof;
        logic        eol;
    } entry_t;

    state_e         state_q, state_d;
    logic [XW-1:0]  x_q, x_d;
    logic [YW-1:0]  y_q, y_d;
    logic [19:0]    base_q, base_d;
    logic           req_q, req_d;
    logic [23:0]    addr_q, addr_d;
    logic           restart_q, restart_d;
    logic           busy_q, busy_d;
    entry_t         fifo_q [FIFO_DEPTH];
    entry_t         fifo_d [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           valid_q, valid_d;
    logic [23:0]    data_q, data_d;
    logic           sof_q, sof_d, eol_q, eol_d;

    logic           push, pop, flush, do_restart;
    logic           x_last, y_last;
    logic [31:0]    full_addr;
    entry_t         push_entry, head;
    logic           unused_rdata_hi;

    function automatic logic [23:0] rgb888(input logic [15:0] p);
        return {p[15:11], p[15:13], p[10:5], p[10:9], p[4:0], p[4:2]};
    endfunction

    assign x_last          = (x_q == XW'(H_ACTIVE - 1));
    assign y_last          = (y_q == YW'(V_ACTIVE - 1));
    assign full_addr       = {base_q, 12'b0} + 32'(y_q) * H_ACTIVE + 32'(x_q);
    assign push_entry      = '{pix: bus.mem_rdata[15:0],
                               sof: (x_q == '0) && (y_q == '0),
                               eol: x_last};
    assign unused_rdata_hi = ^bus.mem_rdata[31:16];

    // Fetch sequencing, restart handling and FIFO/output next-state.
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        base_d     = base_q;
        req_d      = req_q;
        addr_d     = addr_q;
        restart_d  = restart_q;
        busy_d     = busy_q;
        push       = 1'b0;
        do_restart = 1'b0;
        pop        = valid_q && bus.pix_ready;

        case (state_q)
            S_IDLE: begin
                if (frame_start) do_restart = 1'b1;
            end
            S_FETCH: begin
                if (frame_start) begin
                    do_restart = 1'b1;
                end else if ((count_q < CW'(FIFO_DEPTH)) && bus.mem_ready) begin
                    req_d   = 1'b1;
                    addr_d  = full_addr[23:0];
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.mem_ack) begin
                    req_d = 1'b0;
                    if (restart_q || frame_start) begin
                        // Data of the request issued before the restart is dropped.
                        do_restart = 1'b1;
                        restart_d  = 1'b0;
                    end else begin
                        push = 1'b1;
                        if (x_last) begin
                            x_d = '0;
                            if (y_last) begin
                                state_d = S_DRAIN;
                            end else begin
                                y_d     = y_q + YW'(1);
                                state_d = S_FETCH;
                            end
                        end else begin
                            x_d     = x_q + XW'(1);
                            state_d = S_FETCH;
                        end
                    end
                end else if (frame_start) begin
                    // Request must finish first; remember the new base now.
                    restart_d = 1'b1;
                    base_d    = fb_base_addr;
                end
            end
            S_DRAIN: begin
                if (frame_start) begin
                    do_restart = 1'b1;
                end else if (count_q == '0) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        flush = do_restart;
        if (do_restart) begin
            if (frame_start) base_d = fb_base_addr;
            x_d     = '0;
            y_d     = '0;
            busy_d  = 1'b1;
            state_d = S_FETCH;
        end

        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                fifo_d[wr_ptr_q] = push_entry;
                wr_ptr_d         = wr_ptr_q + AW'(1);
            end
            if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end

        head    = fifo_d[rd_ptr_d];
        valid_d = (count_d != '0);
        data_d  = rgb888(head.pix);
        sof_d   = head.sof;
        eol_d   = head.eol;
    end

    // State, FIFO storage and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            x_q       <= '0;
            y_q       <= '0;
            base_q    <= '0;
            req_q     <= 1'b0;
            addr_q    <= '0;
            restart_q <= 1'b0;
            busy_q    <= 1'b0;
            fifo_q    <= '{default: '0};
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            sof_q     <= 1'b0;
            eol_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            base_q    <= base_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            restart_q <= restart_d;
            busy_q    <= busy_d;
            fifo_q    <= fifo_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            sof_q     <= sof_d;
            eol_q     <= eol_d;
        end
    end

    assign bus.mem_req   = req_q;
    assign bus.mem_we    = 1'b0;
    assign bus.mem_addr  = addr_q;
    assign bus.pix_valid = valid_q;
    assign bus.pix_data  = data_q;
    assign bus.pix_sof   = sof_q;
    assign bus.pix_eol   = eol_q;
    assign busy          = busy_q;

`ifdef SCANOUT_UNDERFLOW_CNT_EN
    logic [15:0] ufl_q;

    // Count cycles the consumer wanted a pixel during a frame but none was ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ufl_q <= '0;
        end else if (frame_start) begin
            ufl_q <= '0;
        end else if (busy_q && bus.pix_ready && !valid_q && (ufl_q != 16'hFFFF)) begin
            ufl_q <= ufl_q + 16'd1;
        end
    end

    assign underflow_cnt = ufl_q;
`else
    assign underflow_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_fb_scanout.sv
// tb_fb_scanout: directed bench for fb_scanout at 4x2 pixels, 4-entry FIFO.
module tb_fb_scanout;
    logic        clk;
    logic        rst_n;
    logic        frame_start;
    logic [19:0] fb_base_addr;
    logic        busy;
    logic [15:0] underflow_cnt;

    fb_scanout_if dut_if ();

    fb_scanout #(.H_ACTIVE(4), .V_ACTIVE(2), .FIFO_DEPTH(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .frame_start   (frame_start),
        .fb_base_addr  (fb_base_addr),
        .bus           (dut_if),
        .busy          (busy),
        .underflow_cnt (underflow_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int last_req_cyc = 0;
    int req_rise_cyc = -1;
    logic req_prev = 1'b0;
    logic we_seen = 1'b0;

    int   ack_lat = 0;
    int   lat_cnt = 0;
    logic hold_ack = 1'b0;

    logic [23:0] addr_q [$];
    logic [25:0] pix_q  [$];

    logic [15:0] pix_mem [8] = '{16'hF800, 16'h07E0, 16'h001F, 16'h8410,
                                 16'h1234, 16'hFFFF, 16'h0000, 16'h0841};
    logic [23:0] exp_rgb [8] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h848284,
                                 24'h1045A5, 24'hFFFFFF, 24'h000000, 24'h080808};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] word_of(input logic [23:0] a);
        if (a[23:16] == 8'h03) return 16'hABCD;
        return pix_mem[a[2:0]];
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM arbiter model: ack ack_lat+1 cycles after req, one cycle wide.
    initial begin
        dut_if.mem_ack   = 1'b0;
        dut_if.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (dut_if.mem_ack) begin
                dut_if.mem_ack = 1'b0;
            end else if (dut_if.mem_req && !hold_ack) begin
                if (lat_cnt >= ack_lat) begin
                    dut_if.mem_ack   = 1'b1;
                    dut_if.mem_rdata = {16'hDEAD, word_of(dut_if.mem_addr)};
                    addr_q.push_back(dut_if.mem_addr);
                    lat_cnt = 0;
                end else begin
                    lat_cnt++;
                end
            end
        end
    end

    // Output monitor on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (dut_if.pix_valid && dut_if.pix_ready)
                pix_q.push_back({dut_if.pix_sof, dut_if.pix_eol, dut_if.pix_data});
            if (dut_if.mem_req) last_req_cyc = cyc;
            if (dut_if.mem_req && !req_prev) req_rise_cyc = cyc;
            req_prev = dut_if.mem_req;
            if (dut_if.mem_we) we_seen = 1'b1;
        end
    end

    task automatic do_reset();
        rst_n            = 1'b0;
        frame_start      = 1'b0;
        fb_base_addr     = '0;
        dut_if.pix_ready = 1'b0;
        dut_if.mem_ready = 1'b1;
        hold_ack         = 1'b0;
        ack_lat          = 0;
        lat_cnt          = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        addr_q.delete();
        pix_q.delete();
        req_rise_cyc = -1;
    endtask

    task automatic pulse_start(input logic [19:0] base);
        fb_base_addr = base;
        frame_start  = 1'b1;
        @(posedge clk);
        #1;
        frame_start  = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while ((busy || dut_if.pix_valid) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_done"}, 32'(n < budget), 32'd1);
    endtask

    task automatic check_frame(input string tag, input logic [23:0] base);
        logic [25:0] e;
        check({tag, "_naddr"}, 32'(addr_q.size()), 32'd8);
        for (int i = 0; i < addr_q.size() && i < 8; i++)
            check($sformatf("%s_addr%0d", tag, i), 32'(addr_q[i]), 32'(base + 24'(i)));
        check({tag, "_npix"}, 32'(pix_q.size()), 32'd8);
        for (int i = 0; i < pix_q.size() && i < 8; i++) begin
            e = pix_q[i];
            check($sformatf("%s_data%0d", tag, i), 32'(e[23:0]), 32'(exp_rgb[i]));
            check($sformatf("%s_sof%0d", tag, i), 32'(e[25]), 32'(i == 0));
            check($sformatf("%s_eol%0d", tag, i), 32'(e[24]), 32'(i % 4 == 3));
        end
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int rdy_cyc;
        int n;

        // Reset values.
        do_reset();
        check("rst_req",   32'(dut_if.mem_req),   32'd0);
        check("rst_addr",  32'(dut_if.mem_addr),  32'd0);
        check("rst_valid", 32'(dut_if.pix_valid), 32'd0);
        check("rst_sof",   32'(dut_if.pix_sof),   32'd0);
        check("rst_eol",   32'(dut_if.pix_eol),   32'd0);
        check("rst_busy",  32'(busy),             32'd0);
        check("rst_ufl",   32'(underflow_cnt),    32'd0);

        // Full frame, immediate acks, consumer always ready; colour expansion.
        do_reset();
        dut_if.pix_ready = 1'b1;
        we_seen = 1'b0;
        pulse_start(20'h00010);
        check("t1_busy", 32'(busy), 32'd1);
        wait_idle("t1", 200);
        check_frame("t1", 24'h010000);
        check("t1_we", 32'(we_seen), 32'd0);

        // Consumer stalled: FIFO fills, fetch stops, then resumes losslessly.
        do_reset();
        pulse_start(20'h00020);
        repeat (30) @(posedge clk);
        #1;
        check("t3_nacks",  32'(addr_q.size()), 32'd4);
        check("t3_req",    32'(dut_if.mem_req), 32'd0);
        check("t3_gap",    32'((cyc - last_req_cyc) >= 10), 32'd1);
        check("t3_valid",  32'(dut_if.pix_valid), 32'd1);
        check("t3_nopop",  32'(pix_q.size()), 32'd0);
        dut_if.pix_ready = 1'b1;
        wait_idle("t3", 200);
        check_frame("t3", 24'h020000);

        // Arbiter not ready for 5 cycles.
        do_reset();
        dut_if.pix_ready = 1'b1;
        dut_if.mem_ready = 1'b0;
        pulse_start(20'h00000);
        repeat (5) @(posedge clk);
        #1;
        check("t4_noreq",  32'(dut_if.mem_req), 32'd0);
        check("t4_norise", 32'(req_rise_cyc), 32'hFFFF_FFFF);
        dut_if.mem_ready = 1'b1;
        rdy_cyc = cyc;
        repeat (2) @(posedge clk);
        #1;
        check("t4_rise", 32'(req_rise_cyc), 32'(rdy_cyc + 1));
        wait_idle("t4", 200);
        check_frame("t4", 24'h000000);

        // Restart while a request is outstanding; its data must be dropped.
        do_reset();
        dut_if.pix_ready = 1'b1;
        ack_lat = 4;
        pulse_start(20'h00030);
        n = 0;
        while (!dut_if.mem_req && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("t5_req_up", 32'(dut_if.mem_req), 32'd1);
        pulse_start(20'h00040);
        check("t5_held",      32'(dut_if.mem_req),  32'd1);
        check("t5_held_addr", 32'(dut_if.mem_addr), 32'h030000);
        wait_idle("t5", 300);
        check("t5_nacks", 32'(addr_q.size()), 32'd9);
        if (addr_q.size() > 0) begin
            check("t5_old_addr", 32'(addr_q[0]), 32'h030000);
            void'(addr_q.pop_front());
        end
        check_frame("t5", 24'h040000);

        // Starved consumer counter, then asynchronous reset mid-request.
        do_reset();
        hold_ack = 1'b1;
        pulse_start(20'h00050);
        dut_if.pix_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        dut_if.pix_ready = 1'b0;
`ifdef SCANOUT_UNDERFLOW_CNT_EN
        check("t6_ufl", 32'(underflow_cnt), 32'd6);
`else
        check("t6_ufl", 32'(underflow_cnt), 32'd0);
`endif
        check("t6_wait_req", 32'(dut_if.mem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_req",   32'(dut_if.mem_req),   32'd0);
        check("t6_rst_addr",  32'(dut_if.mem_addr),  32'd0);
        check("t6_rst_valid", 32'(dut_if.pix_valid), 32'd0);
        check("t6_rst_sof",   32'(dut_if.pix_sof),   32'd0);
        check("t6_rst_eol",   32'(dut_if.pix_eol),   32'd0);
        check("t6_rst_busy",  32'(busy),             32'd0);
        check("t6_rst_ufl",   32'(underflow_cnt),    32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
